// File: rtl/dmem_arbiter_if.sv
// Shared data-memory bus bundle: CPU port, debug/loader port and memory port.
// Signal suffixes are from the arbiter's point of view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5
) ();
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_wdata_i;
    logic [31:0]       cpu_rdata_o;
    logic              cpu_stall_o;

    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [31:0]       dbg_addr_i;
    logic [31:0]       dbg_wdata_i;
    logic              dbg_ack_o;
    logic [31:0]       dbg_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_ack_o, dbg_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_ack_o, dbg_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/debug arbiter for a single-port data memory with a starvation guard.
// Define DMEM_ARB_PERF_EN to enable the stall/grant performance counters.
module dmem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_arbiter_if.slave bus,
    output logic [15:0]   cpu_stall_cnt_o,
    output logic [15:0]   dbg_grant_cnt_o
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE, CPU_ACC, CPU_RSP, DBG_ACC, DBG_RSP
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   cpu_rdata_q, dbg_rdata_q;
    logic          dbg_sel, acc, we_sel, in_dbg;
    logic          cpu_done, dbg_done, dbg_grant;
    logic [31:0]   addr_sel, wdata_sel;
    logic          unused_addr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req_i && (starve_q < LIMIT)) state_d = CPU_ACC;
                else if (bus.dbg_req_i)                  state_d = DBG_ACC;
                else if (bus.cpu_req_i)                  state_d = CPU_ACC;
            end
            CPU_ACC: state_d = bus.cpu_we_i ? IDLE : CPU_RSP;
            DBG_ACC: state_d = bus.dbg_we_i ? IDLE : DBG_RSP;
            CPU_RSP: state_d = IDLE;
            DBG_RSP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_dbg    = (state_q == DBG_ACC) || (state_q == DBG_RSP);
    assign dbg_grant = (state_q == IDLE) && (state_d == DBG_ACC);

    // Waiting debug cycles saturate; a grant or a dropped request resets it.
    always_comb begin
        starve_d = starve_q;
        if (!bus.dbg_req_i || dbg_grant)
            starve_d = '0;
        else if (!in_dbg && (starve_q < LIMIT))
            starve_d = starve_q + SW'(1);
    end

    assign dbg_sel   = (state_q == DBG_ACC);
    assign acc       = rst_i && ((state_q == CPU_ACC) || dbg_sel);
    assign we_sel    = dbg_sel ? bus.dbg_we_i    : bus.cpu_we_i;
    assign addr_sel  = dbg_sel ? bus.dbg_addr_i  : bus.cpu_addr_i;
    assign wdata_sel = dbg_sel ? bus.dbg_wdata_i : bus.cpu_wdata_i;

    assign unused_addr = ^{addr_sel[31:ADDR_W], addr_sel[1:0]};

    assign bus.mem_en_o    = acc;
    assign bus.mem_we_o    = acc && we_sel;
    assign bus.mem_addr_o  = acc ? {addr_sel[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata_o = acc ? wdata_sel : '0;

    // Completions are masked while reset is asserted so an abort never acks.
    assign cpu_done = rst_i && ((state_q == CPU_RSP) ||
                                ((state_q == CPU_ACC) && bus.cpu_we_i));
    assign dbg_done = rst_i && ((state_q == DBG_RSP) ||
                                (dbg_sel && bus.dbg_we_i));

    assign bus.cpu_stall_o = bus.cpu_req_i && !cpu_done;
    assign bus.dbg_ack_o   = dbg_done;

    assign bus.cpu_rdata_o = (rst_i && (state_q == CPU_RSP)) ?
                             bus.mem_rdata_i : cpu_rdata_q;
    assign bus.dbg_rdata_o = (rst_i && (state_q == DBG_RSP)) ?
                             bus.mem_rdata_i : dbg_rdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (state_q == CPU_RSP) cpu_rdata_q <= bus.mem_rdata_i;
            if (state_q == DBG_RSP) dbg_rdata_q <= bus.mem_rdata_i;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_cnt_q, grant_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            if (bus.cpu_stall_o && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (dbg_grant && (grant_cnt_q != 16'hFFFF))
                grant_cnt_q <= grant_cnt_q + 16'd1;
        end
    end

    assign cpu_stall_cnt_o = stall_cnt_q;
    assign dbg_grant_cnt_o = grant_cnt_q;
`else
    assign cpu_stall_cnt_o = '0;
    assign dbg_grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle table, then a contention run
// and random traffic checked against a transaction-timing model.
module tb_dmem_arbiter;
    localparam int AW  = 5;
    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] stall_cnt, grant_cnt;

    dmem_arbiter_if #(.ADDR_W(AW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .bus             (bus),
        .cpu_stall_cnt_o (stall_cnt),
        .dbg_grant_cnt_o (grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] preload(int w);
        return (w == 1) ? 32'd7 : 32'(32'h100 + w);
    endfunction

    // Environment memory: synchronous read, data the cycle after enable.
    logic [31:0] mem [8];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 8; i++) mem[i] <= preload(i);
            loaded <= 1'b1;
        end else if (bus.mem_en_o) begin
            if (bus.mem_we_o) mem[bus.mem_addr_o[4:2]] <= bus.mem_wdata_o;
            else bus.mem_rdata_i <= mem[bus.mem_addr_o[4:2]];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dreq;
        logic [31:0] daddr;
        logic        stall, ack, en, we;
        logic [31:0] maddr, crd, drd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rst, creq, cwe,
                                logic [31:0] caddr, cwd,
                                logic dreq, logic [31:0] daddr,
                                logic stall, ack, en, we,
                                logic [31:0] maddr, crd, drd);
        vec_t v;
        v.rst = rst;     v.creq = creq;   v.cwe = cwe;
        v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq;   v.daddr = daddr;
        v.stall = stall; v.ack = ack;     v.en = en;  v.we = we;
        v.maddr = maddr; v.crd = crd;     v.drd = drd;
        return v;
    endfunction

    // Transaction-timing reference model (absolute cycle numbers).
    int          cyc, free_at, grant_cyc, done_cyc, owner, starve;
    logic        o_we;
    logic [31:0] o_addr, o_wd;
    logic [31:0] ref_mem [8];
    logic [31:0] m_crd, m_drd;
    int          m_stalls, m_grants;
    bit          cpu_done, dbg_done, cpu_pend, dbg_pend;

    task automatic model_reset();
        cyc = 0; free_at = 0; owner = 0; starve = 0;
        grant_cyc = -10; done_cyc = -10;
        m_crd = '0; m_drd = '0; m_stalls = 0; m_grants = 0;
        cpu_done = 0; dbg_done = 0; cpu_pend = 0; dbg_pend = 0;
        o_we = 1'b0; o_addr = '0; o_wd = '0;
    endtask

    task automatic model_step();
        int          win;
        bit          acc, done, serving;
        logic        e_stall;
        logic [31:0] rd, e_crd, e_drd;
        win = 0;
        if (cyc >= free_at) begin
            owner = 0;
            if (bus.cpu_req_i && starve < LIM) win = 1;
            else if (bus.dbg_req_i)            win = 2;
            else if (bus.cpu_req_i)            win = 1;
            if (win != 0) begin
                owner = win; grant_cyc = cyc; free_at = cyc + 100;
            end
        end
        acc = (owner != 0) && (cyc == grant_cyc + 1);
        if (acc) begin
            o_we   = (owner == 1) ? bus.cpu_we_i    : bus.dbg_we_i;
            o_addr = (owner == 1) ? bus.cpu_addr_i  : bus.dbg_addr_i;
            o_wd   = (owner == 1) ? bus.cpu_wdata_i : bus.dbg_wdata_i;
            done_cyc = o_we ? cyc : cyc + 1;
            free_at  = done_cyc + 1;
        end
        done    = (owner != 0) && (cyc > grant_cyc) && (cyc == done_cyc);
        serving = (owner == 2) && (cyc > grant_cyc);
        rd = ref_mem[o_addr[4:2]];
        e_crd = m_crd; e_drd = m_drd;
        if (done && !o_we) begin
            if (owner == 1) e_crd = rd;
            else e_drd = rd;
        end
        e_stall = bus.cpu_req_i && !(done && owner == 1);
        chk1("rnd.stall", bus.cpu_stall_o, e_stall);
        chk1("rnd.ack", bus.dbg_ack_o, done && owner == 2);
        chk1("rnd.en", bus.mem_en_o, acc);
        chk("rnd.crd", bus.cpu_rdata_o, e_crd);
        chk("rnd.drd", bus.dbg_rdata_o, e_drd);
        if (acc) begin
            chk1("rnd.we", bus.mem_we_o, o_we);
            chk("rnd.maddr", {27'b0, bus.mem_addr_o}, {27'b0, o_addr[4:2], 2'b00});
            if (o_we) chk("rnd.wdata", bus.mem_wdata_o, o_wd);
        end
        if (done && o_we) ref_mem[o_addr[4:2]] = o_wd;
        m_crd = e_crd; m_drd = e_drd;
        if (e_stall) m_stalls++;
        if (win == 2) m_grants++;
        if (!bus.dbg_req_i || win == 2) starve = 0;
        else if (!serving && starve < LIM) starve++;
        cpu_done = done && owner == 1;
        dbg_done = done && owner == 2;
        cyc++;
    endtask

    task automatic drive(input bit both);
        if (cpu_done) cpu_pend = 0;
        if (dbg_done) dbg_pend = 0;
        if (!cpu_pend) begin
            if (both || $urandom_range(2) == 0) begin
                cpu_pend = 1;
                bus.cpu_req_i   = 1'b1;
                bus.cpu_we_i    = both ? 1'b0 : 1'($urandom_range(1));
                bus.cpu_addr_i  = both ? 32'h4 : $urandom;
                bus.cpu_wdata_i = $urandom;
            end else bus.cpu_req_i = 1'b0;
        end
        if (!dbg_pend) begin
            if (both || $urandom_range(3) == 0) begin
                dbg_pend = 1;
                bus.dbg_req_i   = 1'b1;
                bus.dbg_we_i    = both ? 1'b0 : 1'($urandom_range(1));
                bus.dbg_addr_i  = both ? 32'h1c : $urandom;
                bus.dbg_wdata_i = $urandom;
            end else bus.dbg_req_i = 1'b0;
        end
    endtask

    task automatic chk_perf(string tag);
`ifdef DMEM_ARB_PERF_EN
        chk({tag, ".stall_cnt"}, {16'b0, stall_cnt}, 32'(m_stalls));
        chk({tag, ".grant_cnt"}, {16'b0, grant_cnt}, 32'(m_grants));
`else
        chk({tag, ".stall_cnt"}, {16'b0, stall_cnt}, 32'd0);
        chk({tag, ".grant_cnt"}, {16'b0, grant_cnt}, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0;
        bus.cpu_addr_i = '0;  bus.cpu_wdata_i = '0;
        bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0;
        bus.dbg_addr_i = '0;  bus.dbg_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;

        //          rst c  we caddr  cwd     d daddr stl ack en we maddr crd     drd
        vt.push_back(mk(0, 0, 0, 0,     0,      0, 0,    0, 0, 0, 0, 0,    0,      0));
        vt.push_back(mk(0, 1, 0, 4,     0,      0, 0,    1, 0, 0, 0, 0,    0,      0));
        vt.push_back(mk(1, 1, 0, 4,     0,      0, 0,    1, 0, 0, 0, 0,    0,      0));
        vt.push_back(mk(1, 1, 0, 4,     0,      0, 0,    1, 0, 1, 0, 4,    0,      0));
        vt.push_back(mk(1, 1, 0, 4,     0,      0, 0,    0, 0, 0, 0, 0,    7,      0));
        vt.push_back(mk(1, 0, 0, 0,     0,      0, 0,    0, 0, 0, 0, 0,    7,      0));
        vt.push_back(mk(1, 1, 1, 8,     5,      0, 0,    1, 0, 0, 0, 0,    7,      0));
        vt.push_back(mk(1, 1, 1, 8,     5,      0, 0,    0, 0, 1, 1, 8,    7,      0));
        vt.push_back(mk(1, 0, 0, 0,     0,      0, 0,    0, 0, 0, 0, 0,    7,      0));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 'h1c, 0, 0, 0, 0, 0,    7,      0));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 'h1c, 0, 0, 1, 0, 'h1c, 7,      0));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 'h1c, 0, 1, 0, 0, 0,    7,      'h107));
        vt.push_back(mk(1, 0, 0, 0,     0,      0, 0,    0, 0, 0, 0, 0,    7,      'h107));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 'h0a, 0, 0, 0, 0, 0,    7,      'h107));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 'h0a, 0, 0, 1, 0, 8,    7,      'h107));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 'h0a, 0, 1, 0, 0, 0,    7,      5));
        vt.push_back(mk(1, 1, 0, 4,     0,      1, 0,    1, 0, 0, 0, 0,    7,      5));
        vt.push_back(mk(1, 1, 0, 4,     0,      1, 0,    1, 0, 1, 0, 4,    7,      5));
        vt.push_back(mk(1, 1, 0, 4,     0,      1, 0,    0, 0, 0, 0, 0,    7,      5));
        vt.push_back(mk(1, 1, 0, 8,     0,      1, 0,    1, 0, 0, 0, 0,    7,      5));
        vt.push_back(mk(1, 1, 0, 8,     0,      1, 0,    1, 0, 1, 0, 0,    7,      5));
        vt.push_back(mk(1, 1, 0, 8,     0,      1, 0,    1, 1, 0, 0, 0,    7,      'h100));
        vt.push_back(mk(1, 1, 0, 8,     0,      1, 0,    1, 0, 0, 0, 0,    7,      'h100));
        vt.push_back(mk(1, 1, 0, 8,     0,      1, 0,    1, 0, 1, 0, 8,    7,      'h100));
        vt.push_back(mk(1, 1, 0, 8,     0,      1, 0,    0, 0, 0, 0, 0,    5,      'h100));
        vt.push_back(mk(1, 0, 0, 0,     0,      0, 0,    0, 0, 0, 0, 0,    5,      'h100));
        vt.push_back(mk(1, 1, 0, 'h1c,  0,      0, 0,    1, 0, 0, 0, 0,    5,      'h100));
        vt.push_back(mk(1, 1, 0, 'h1c,  0,      0, 0,    1, 0, 1, 0, 'h1c, 5,      'h100));
        vt.push_back(mk(0, 1, 0, 'h1c,  0,      0, 0,    1, 0, 0, 0, 0,    5,      'h100));
        vt.push_back(mk(1, 1, 0, 'h1c,  0,      0, 0,    1, 0, 0, 0, 0,    0,      0));
        vt.push_back(mk(1, 1, 0, 'h1c,  0,      0, 0,    1, 0, 1, 0, 'h1c, 0,      0));
        vt.push_back(mk(1, 1, 0, 'h1c,  0,      0, 0,    0, 0, 0, 0, 0,    'h107,  0));
        vt.push_back(mk(1, 0, 0, 0,     0,      0, 0,    0, 0, 0, 0, 0,    'h107,  0));
        vt.push_back(mk(1, 1, 1, 0,     'hdead, 0, 0,    1, 0, 0, 0, 0,    'h107,  0));
        vt.push_back(mk(0, 1, 1, 0,     'hdead, 0, 0,    1, 0, 0, 0, 0,    'h107,  0));
        vt.push_back(mk(1, 0, 0, 0,     0,      0, 0,    0, 0, 0, 0, 0,    0,      0));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 0,    0, 0, 0, 0, 0,    0,      0));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 0,    0, 0, 1, 0, 0,    0,      0));
        vt.push_back(mk(1, 0, 0, 0,     0,      1, 0,    0, 1, 0, 0, 0,    0,      'h100));
        vt.push_back(mk(1, 0, 0, 0,     0,      0, 0,    0, 0, 0, 0, 0,    0,      'h100));

        foreach (vt[i]) begin
            rst_n           = vt[i].rst;
            bus.cpu_req_i   = vt[i].creq;
            bus.cpu_we_i    = vt[i].cwe;
            bus.cpu_addr_i  = vt[i].caddr;
            bus.cpu_wdata_i = vt[i].cwd;
            bus.dbg_req_i   = vt[i].dreq;
            bus.dbg_we_i    = 1'b0;
            bus.dbg_addr_i  = vt[i].daddr;
            bus.dbg_wdata_i = '0;
            @(negedge clk);
            chk1($sformatf("r%0d.stall", i), bus.cpu_stall_o, vt[i].stall);
            chk1($sformatf("r%0d.ack", i), bus.dbg_ack_o, vt[i].ack);
            chk1($sformatf("r%0d.en", i), bus.mem_en_o, vt[i].en);
            chk($sformatf("r%0d.crd", i), bus.cpu_rdata_o, vt[i].crd);
            chk($sformatf("r%0d.drd", i), bus.dbg_rdata_o, vt[i].drd);
            if (vt[i].en) begin
                chk1($sformatf("r%0d.we", i), bus.mem_we_o, vt[i].we);
                chk($sformatf("r%0d.maddr", i), {27'b0, bus.mem_addr_o}, vt[i].maddr);
            end
            @(posedge clk);
            #1;
        end

        // Continuous CPU/debug read contention from reset, then counters.
        rst_n = 1'b0;
        bus.cpu_req_i = 1'b0;
        bus.dbg_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int w = 0; w < 8; w++) ref_mem[w] = preload(w);
        ref_mem[2] = 32'h5;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1);
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
        end
        drive(1'b1);
        @(negedge clk);
        chk_perf("contend");
        model_step();
        @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            drive(1'b0);
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
        end
        drive(1'b0);
        @(negedge clk);
        chk_perf("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, byte-address width of the shared data memory (32 bytes).
REQ-002 Parameter STARVE_LIMIT, default 3, consecutive lost-arbitration cycles before debug port forced priority.
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-low reset.
REQ-005 cpu_req_i  input  1  MEM-stage access request, held until served.
REQ-006 cpu_we_i  input  1  1 = store word, 0 = load word.
REQ-007 cpu_addr_i  input  32  byte address; bits [ADDR_W-1:2] used, low 2 bits ignored.
REQ-008 cpu_wdata_i  input  32  store data.
REQ-009 cpu_rdata_o  output  32  load data, valid in the cycle cpu_stall_o falls for a load.
REQ-010 cpu_stall_o  output  1  pipeline stall request to the hazard logic.
REQ-011 dbg_req_i / dbg_we_i / dbg_addr_i[31:0] / dbg_wdata_i[31:0]  input  debug/loader port, same meaning as CPU fields.
REQ-012 dbg_ack_o  output  1  one-cycle completion pulse; dbg_rdata_o  output  32  valid with ack on reads.
REQ-013 mem_en_o, mem_we_o  output  1 each; mem_addr_o  output  ADDR_W; mem_wdata_o  output  32; mem_rdata_i  input  32, synchronous read, data valid the cycle after mem_en_o.

Function
REQ-014 FSM states: IDLE, CPU_ACC, CPU_RSP, DBG_ACC, DBG_RSP; encoding registered.
REQ-015 IDLE: cpu_req_i and starve_cnt < STARVE_LIMIT -> CPU_ACC; else dbg_req_i -> DBG_ACC; else cpu_req_i -> CPU_ACC; else stay.
REQ-016 xxx_ACC: mem_en_o=1, mem_we_o/addr/wdata driven from the granted port; write -> IDLE with completion this cycle; read -> xxx_RSP.
REQ-017 xxx_RSP: mem_rdata_i registered into granted port's rdata_o, completion this cycle, -> IDLE.
REQ-018 cpu_stall_o = cpu_req_i AND NOT (CPU completion this cycle); combinational.
REQ-019 Latency from request cycle: write 2 cycles, read 3 cycles, when uncontended.
REQ-020 starve_cnt (saturating at STARVE_LIMIT): +1 each cycle dbg_req_i=1 and state not DBG_*; cleared on entry to DBG_ACC or when dbg_req_i=0.
REQ-021 mem_en_o=0, mem_we_o=0 in IDLE and RSP states; mem_addr_o = addr[ADDR_W-1:2] with [1:0]=0.
REQ-022 Requester fields sampled in ACC cycle; request dropped mid-transaction -> transaction still completes, no effect on FSM.
REQ-023 rdata_o outputs hold last loaded value until next read completion for that port.
REQ-024 Simultaneous requests with starve_cnt = STARVE_LIMIT: debug wins exactly once, then CPU regains priority.

Reset
REQ-025 rst_i=0 at a rising edge: state IDLE, starve_cnt 0, cpu_rdata_o and dbg_rdata_o 0, dbg_ack_o 0, mem_en_o/mem_we_o 0.
REQ-026 Reset during ACC/RSP aborts: no ack, no stall release pulse, any pending write not reissued.
REQ-027 cpu_stall_o during reset follows REQ-018 with FSM in IDLE.

Configuration
REQ-028 Macro DMEM_ARB_PERF_EN defined: outputs cpu_stall_cnt_o[15:0] (cycles cpu_stall_o=1) and dbg_grant_cnt_o[15:0] (DBG_ACC entries), saturating at 16'hFFFF, cleared by reset.
REQ-029 Macro undefined: both ports present, tied to 0, no counter flops.

Verification
REQ-030 CPU read only, mem word 0x04 = 7: cpu_req_i addr 0x04 we=0 -> stall 2 cycles, cpu_rdata_o=7 in 3rd cycle, stall low.
REQ-031 CPU write addr 0x08 data 0x5: mem_en_o=mem_we_o=1, mem_addr_o=0x08 in cycle 2, stall low in cycle 2, back in IDLE cycle 3.
REQ-032 CPU and debug both requesting continuously (reads): debug granted after 3 lost cycles, single dbg_ack_o with correct data, then CPU served next.
REQ-033 Debug read alone addr 0x1c: dbg_ack_o pulse 1 cycle in cycle 3, cpu_stall_o stays 0.
REQ-034 rst_i low during CPU_RSP: next cycle state IDLE, no ack, rdata 0; re-request completes normally.
REQ-035 With DMEM_ARB_PERF_EN, scenario REQ-032 over 20 cycles: counters match bench-counted stall cycles and debug grants; without macro both read 0.
